instr_fetch_reg: RTL

//  Instruction fetch and instruction-register stage upstream of the control unit (UC).
//  On the UC fetch request, issues a req/ack read of the 32-bit word at the current PC
//  and latches it into the instruction register (IR).

---
 rtl/instr_fetch_reg.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_reg.sv
// Instruction fetch + instruction register: req/ack fetch of the word at PC, IR decode to fields/immediates.
// Optional build macro FETCH_TIMEOUT_EN aborts a fetch that waits too long for mem_ack.
module instr_fetch_reg #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic [63:0] pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic        fetch_err,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [63:0] imm_pc,
    output logic [63:0] imm_alu
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_memReq;
    logic        w_memReqNext;
    logic [63:0] r_memAddr;
    logic [63:0] w_memAddrNext;
    logic [31:0] r_ir;
    logic [31:0] w_irNext;
    logic        r_instrValid;
    logic        w_instrValidNext;
    logic        r_fetchErr;
    logic        w_fetchErrNext;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_toCount;
    logic [CNT_W-1:0] w_toCountNext;
    logic             w_timeout;

    assign w_timeout = (r_toCount == CNT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_memReq     <= 1'b0;
            r_memAddr    <= 64'd0;
            r_ir         <= NOP_INSTR;
            r_instrValid <= 1'b0;
            r_fetchErr   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_toCount    <= '0;
`endif
        end else begin
            r_state      <= w_stateNext;
            r_memReq     <= w_memReqNext;
            r_memAddr    <= w_memAddrNext;
            r_ir         <= w_irNext;
            r_instrValid <= w_instrValidNext;
            r_fetchErr   <= w_fetchErrNext;
`ifdef FETCH_TIMEOUT_EN
            r_toCount    <= w_toCountNext;
`endif
        end
    end

    // Every registered output is computed here as a next value; fetch_en is only honoured outside REQ.
    always_comb begin
        w_stateNext      = r_state;
        w_memReqNext     = r_memReq;
        w_memAddrNext    = r_memAddr;
        w_irNext         = r_ir;
        w_instrValidNext = r_instrValid;
        w_fetchErrNext   = r_fetchErr;
`ifdef FETCH_TIMEOUT_EN
        w_toCountNext    = r_toCount;
`endif
        case (r_state)
            IDLE, VALID, ERR: begin
                if (fetch_en) begin
                    w_instrValidNext = 1'b0;
                    if (pc[1:0] == 2'b00) begin
                        w_stateNext    = REQ;
                        w_memAddrNext  = pc;
                        w_memReqNext   = 1'b1;
                        w_fetchErrNext = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        w_toCountNext  = '0;
`endif
                    end else begin
                        w_stateNext    = ERR;
                        w_memReqNext   = 1'b0;
                        w_fetchErrNext = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    w_stateNext      = VALID;
                    w_irNext         = mem_rdata;
                    w_memReqNext     = 1'b0;
                    w_instrValidNext = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_timeout) begin
                    w_stateNext      = ERR;
                    w_memReqNext     = 1'b0;
                    w_fetchErrNext   = 1'b1;
                    w_instrValidNext = 1'b0;
                end else begin
                    w_toCountNext = r_toCount + 1'b1;
                end
`endif
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign mem_req     = r_memReq;
    assign mem_addr    = r_memAddr;
    assign instr_valid = r_instrValid;
    assign fetch_err   = r_fetchErr;

    assign opcode = r_ir[6:0];
    assign rd     = r_ir[11:7];
    assign funct3 = r_ir[14:12];
    assign rs1    = r_ir[19:15];
    assign rs2    = r_ir[24:20];
    assign funct7 = r_ir[31:25];

    logic [63:0] w_immI;
    logic [63:0] w_immS;
    logic [63:0] w_immB;
    logic [63:0] w_immJ;
    logic [63:0] w_immU;

    assign w_immI = {{52{r_ir[31]}}, r_ir[31:20]};
    assign w_immS = {{52{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_immB = {{51{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_immJ = {{43{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_immU = {{32{r_ir[31]}}, r_ir[31:12], 12'd0};

    // Control-flow immediates go to the UC, operand immediates to the datapath.
    always_comb begin
        imm_pc  = 64'd0;
        imm_alu = 64'd0;
        case (r_ir[6:0])
            OP_JAL:    imm_pc = w_immJ;
            OP_BRANCH: imm_pc = w_immB;
            OP_JALR:   imm_pc = w_immI;
            default:   imm_pc = 64'd0;
        endcase
        case (r_ir[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm_alu = w_immI;
            OP_STORE:                 imm_alu = w_immS;
            OP_LUI, OP_AUIPC:         imm_alu = w_immU;
            default:                  imm_alu = 64'd0;
        endcase
    end

endmodule
